// File: rtl/ysyx_22050854_idu_imm_ctrl_if.sv
// ysyx_22050854_idu_imm_ctrl_if: IFU-side and downstream handshake bundle of the decode front controller.
// Revision 1.0
`default_nettype none

interface ysyx_22050854_idu_imm_ctrl_if #(
  parameter int PC_W = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [2:0]      out_extop;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_extop, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_extop, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050854_idu_imm_ctrl.sv
// ysyx_22050854_idu_imm_ctrl: 2-entry skid FIFO classifying opcodes into ExtOP; perf counters under YSYX_22050854_IDU_PERF_EN.
// Revision 1.0
`default_nettype none

module ysyx_22050854_idu_imm_ctrl #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  ysyx_22050854_idu_imm_ctrl_if.slave bus
`ifdef YSYX_22050854_IDU_PERF_EN
  ,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall
`endif
);

  logic            push;
  logic            pop;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            in_ready_q, in_ready_d;
  logic [31:0]     instr_q   [DEPTH];
  logic [31:0]     instr_d   [DEPTH];
  logic [PC_W-1:0] pc_q      [DEPTH];
  logic [PC_W-1:0] pc_d      [DEPTH];
  logic [2:0]      extop_q   [DEPTH];
  logic [2:0]      extop_d   [DEPTH];
  logic            illegal_q [DEPTH];
  logic            illegal_d [DEPTH];
  logic [2:0]      new_extop;
  logic            new_illegal;

  // Classification is done once at push and travels with the entry.
  always_comb begin
    new_extop   = 3'b111;
    new_illegal = 1'b0;
    case (bus.in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011:             new_extop = 3'b000;
      7'b0110111, 7'b0010111:             new_extop = 3'b001;
      7'b0100011:                         new_extop = 3'b010;
      7'b1100011:                         new_extop = 3'b011;
      7'b1101111:                         new_extop = 3'b100;
      7'b1101011:                         new_extop = 3'b101;
      7'b0110011, 7'b0111011:             new_extop = 3'b111;
      default: begin
        new_extop   = 3'b111;
        new_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    push      = bus.in_valid & in_ready_q & ~flush;
    pop       = (count_q != 2'd0) & bus.out_ready & ~flush;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    extop_d   = extop_q;
    illegal_d = illegal_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q]   = bus.in_instr;
        pc_d[wr_ptr_q]      = bus.in_pc;
        extop_d[wr_ptr_q]   = new_extop;
        illegal_d[wr_ptr_q] = new_illegal;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
    in_ready_d = (count_d < 2'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]   <= '0;
        pc_q[i]      <= '0;
        extop_q[i]   <= 3'b111;
        illegal_q[i] <= 1'b0;
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]   <= instr_d[i];
        pc_q[i]      <= pc_d[i];
        extop_q[i]   <= extop_d[i];
        illegal_q[i] <= illegal_d[i];
      end
    end
  end

  // Head slot is never written while valid, so outputs stay stable under backpressure.
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_instr   = instr_q[rd_ptr_q];
  assign bus.out_pc      = pc_q[rd_ptr_q];
  assign bus.out_extop   = (count_q != 2'd0) ? extop_q[rd_ptr_q] : 3'b111;
  assign bus.out_illegal = (count_q != 2'd0) & illegal_q[rd_ptr_q];

`ifdef YSYX_22050854_IDU_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issue_d = perf_issue_q + {31'd0, pop};
    perf_stall_d = perf_stall_q + {31'd0, bus.out_valid & ~bus.out_ready};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050854_idu_imm_ctrl.sv
// Self-checking bench for ysyx_22050854_idu_imm_ctrl: directed steps plus random traffic against a queue model.
// Revision 1.0
`default_nettype none

module tb_ysyx_22050854_idu_imm_ctrl;
  localparam int PC_W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ysyx_22050854_idu_imm_ctrl_if #(.PC_W(PC_W)) bus ();

`ifdef YSYX_22050854_IDU_PERF_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_stall;
`endif

  ysyx_22050854_idu_imm_ctrl #(.DEPTH(2), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
`ifdef YSYX_22050854_IDU_PERF_EN
    ,
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t            mq[$];
  logic            m_rdy = 1'b0;
  int unsigned     m_issue = 0;
  int unsigned     m_stall = 0;
  int              n_assert = 0;
  int              n_fail = 0;
  logic [31:0]     pend[$];
  logic [PC_W-1:0] pc_next;
  logic [6:0]      ops [0:11];

  // Expected {illegal, extop} straight from the opcode table.
  function automatic logic [3:0] ref_cls(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: return 4'b0_000;
      7'h37, 7'h17:                      return 4'b0_001;
      7'h23:                             return 4'b0_010;
      7'h63:                             return 4'b0_011;
      7'h6F:                             return 4'b0_100;
      7'h6B:                             return 4'b0_101;
      7'h33, 7'h3B:                      return 4'b0_111;
      default:                           return 4'b1_111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] cls;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, m_rdy});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      cls = ref_cls(mq[0].instr);
      chk("out_instr", {32'd0, bus.out_instr}, {32'd0, mq[0].instr});
      chk("out_pc", bus.out_pc, mq[0].pc);
      chk("out_extop", {61'd0, bus.out_extop}, {61'd0, cls[2:0]});
      chk("out_illegal", {63'd0, bus.out_illegal}, {63'd0, cls[3]});
    end else begin
      chk("empty_extop", {61'd0, bus.out_extop}, 64'd7);
      chk("empty_illegal", {63'd0, bus.out_illegal}, 64'd0);
    end
`ifdef YSYX_22050854_IDU_PERF_EN
    chk("perf_issue", {32'd0, perf_issue}, {32'd0, m_issue});
    chk("perf_stall", {32'd0, perf_stall}, {32'd0, m_stall});
`endif
  endtask

  // One clock: drive inputs, advance the model across the edge, check 1 time unit later.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                      input logic ordy, input logic fl, output logic pushed);
    logic do_push, do_pop, stall;
    ent_t tmp;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    do_push = iv && m_rdy && !fl;
    do_pop  = (mq.size() != 0) && ordy && !fl;
    stall   = (mq.size() != 0) && !ordy;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) tmp = mq.pop_front();
      if (do_push) begin
        tmp.instr = ins;
        tmp.pc    = pc;
        mq.push_back(tmp);
      end
    end
    m_rdy   = (mq.size() < 2);
    m_issue = m_issue + (do_pop ? 1 : 0);
    m_stall = m_stall + (stall ? 1 : 0);
    pushed  = do_push;
    #1;
    check_all();
  endtask

  // Offer pending instructions in order, advancing only on acceptance.
  task automatic run_pend(input int n, input logic ordy);
    logic pushed;
    logic iv;
    logic [31:0] ins;
    for (int k = 0; k < n; k++) begin
      iv  = (pend.size() != 0);
      ins = iv ? pend[0] : $urandom;
      step(iv, ins, pc_next, ordy, 1'b0, pushed);
      if (pushed) begin
        ins = pend.pop_front();
        pc_next = pc_next + 64'd4;
      end
    end
  endtask

  initial begin
    logic pushed;
    logic [31:0] rins;
    ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h1B; ops[3]  = 7'h67;
    ops[4] = 7'h73; ops[5] = 7'h37; ops[6] = 7'h17; ops[7]  = 7'h23;
    ops[8] = 7'h63; ops[9] = 7'h6F; ops[10] = 7'h6B; ops[11] = 7'h33;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    // Reset values while rst_n is held low.
    #2;
    chk("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    check_all();
    #1 rst_n = 1'b1;

    // First instruction after reset release.
    step(1'b1, 32'h00500093, 64'h80000000, 1'b1, 1'b0, pushed);
    step(1'b1, 32'h00500093, 64'h80000000, 1'b1, 1'b0, pushed);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, pushed);

    // Back-to-back pushes under backpressure, then drain.
    pc_next = 64'h80000100;
    pend.push_back(32'h123450b7);
    pend.push_back(32'h00112023);
    pend.push_back(32'h00208463);
    pend.push_back(32'h008000ef);
    run_pend(4, 1'b0);
    chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    run_pend(6, 1'b1);

    // Steady state at one entry with simultaneous push and pop.
    pend.push_back(32'h00000013);
    run_pend(1, 1'b0);
    for (int k = 0; k < 10; k++) pend.push_back({$urandom_range(0, 32'h1FFFFFF), 7'h13});
    run_pend(10, 1'b1);
    run_pend(2, 1'b1);

    // Illegal, no-immediate and trap opcodes.
    pend.push_back(32'h0000007F);
    pend.push_back(32'h002081b3);
    pend.push_back(32'h0000006B);
    run_pend(5, 1'b1);

    // Flush while full with a same-cycle input.
    pend.push_back(32'h00100093);
    pend.push_back(32'h00200113);
    run_pend(3, 1'b0);
    step(1'b1, 32'h00300193, 64'h90000000, 1'b1, 1'b1, pushed);
    pend.push_back(32'h00400213);
    run_pend(3, 1'b1);

    // Random traffic, including in_instr changes while not ready.
    for (int k = 0; k < 400; k++) begin
      rins = $urandom;
      if ($urandom_range(0, 3) != 0) rins[6:0] = ops[$urandom_range(0, 11)];
      step($urandom_range(0, 3) != 0, rins, {32'd0, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, pushed);
    end

    // Asynchronous reset mid-cycle with the FIFO full.
    for (int k = 0; k < 5 && mq.size() < 2; k++) begin
      step(1'b1, 32'h00500093, 64'hA0000000, 1'b0, 1'b0, pushed);
    end
    chk("pre_reset_full", {63'd0, bus.in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_rdy   = 1'b0;
    m_issue = 0;
    m_stall = 0;
    check_all();
    #3 rst_n = 1'b1;
    step(1'b1, 32'h00000517, 64'hB0000000, 1'b1, 1'b0, pushed);
    step(1'b1, 32'h00000517, 64'hB0000000, 1'b1, 1'b0, pushed);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ysyx_22050854_idu_imm_ctrl.md
Name: ysyx_22050854_idu_imm_ctrl

Overview:
Decode-stage front controller between the IFU and the immediate generator / ID-EX datapath. It accepts fetched instructions over a valid/ready handshake and classifies each opcode into the immediate-format select (ExtOP). It buffers up to two decoded entries in a skid FIFO and presents {instr, pc, ExtOP, illegal} to the downstream stage. The ExtOP output drives the immediate generator's ExtOP select directly; flush support handles branch redirects.

Parameters:
DEPTH, 2, FIFO entries; fixed at 2; other values unsupported.
PC_W, 64, width of the PC field.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; drops all buffered entries
in_valid  input  1  IFU has an instruction
in_ready  output  1  controller can accept this cycle
in_instr  input  32  fetched instruction
in_pc  input  PC_W  PC of in_instr
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head this cycle
out_instr  output  32  head instruction; feeds immediate generator instr
out_pc  output  PC_W  head PC
out_extop  output  3  immediate format select; feeds immediate generator ExtOP
out_illegal  output  1  head opcode unrecognised

Behaviour:
- Reset (rst_n low, async): count=0, rd/wr pointers=0, out_valid=0, in_ready=0, out_instr=0, out_pc=0, out_extop=3'b111, out_illegal=0. in_ready rises on the first clk edge after rst_n deasserts.
- in_ready is registered: 1 iff count<2 (and not in reset). It never depends combinationally on out_ready.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- count' = count + push - pop. At count=2, push is impossible. At count=1, simultaneous push and pop leaves count=1 with the new entry behind the head.
- Pointers are 1 bit and wrap 1->0.
- Latency: an instruction pushed at edge N is visible on out_* after edge N, i.e. 1 cycle, with an empty FIFO.
- Outputs come from the head entry register. They must hold stable while out_valid & ~out_ready.
- When empty: out_valid=0, out_extop=3'b111, out_illegal=0, out_instr/out_pc hold last value (don't care).
- ExtOP classification is computed at push from in_instr[6:0] and stored with the entry:
  - 0000011 load, 0010011 op-imm, 0011011 op-imm-32, 1100111 jalr, 1110011 system -> 000 (I)
  - 0110111 lui, 0010111 auipc -> 001 (U)
  - 0100011 store -> 010 (S)
  - 1100011 branch -> 011 (B)
  - 1101111 jal -> 100 (J)
  - 1101011 (npc trap opcode) -> 101 (raw-opcode immediate)
  - 0110011 op, 0111011 op-32 -> 111 (no immediate; generator yields 0), illegal=0
  - any other opcode -> 111, illegal=1
- flush: at the edge, count=0 and pointers=0. A same-cycle push and pop are both discarded. out_valid=0 next cycle and in_ready=1 next cycle.
- Flush has priority over push and pop. Reset has priority over flush.
- Reset mid-operation: all entries are discarded immediately and asynchronously. No partial entry survives.
- in_instr/in_pc are sampled only on push. Changes while ~in_ready are ignored.

Optional Feature:
Macro YSYX_22050854_IDU_PERF_EN.
- Defined: adds output ports perf_issue (32 bits) and perf_stall (32 bits).
  - perf_issue increments on every pop.
  - perf_stall increments every cycle with out_valid & ~out_ready.
  - Both reset to 0 on rst_n, are unaffected by flush, and wrap modulo 2^32.
- Undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- Reset release, in_valid=1, instr=0x00500093 (addi), pc=0x80000000, out_ready=1 -> in_ready=1 one cycle after reset. Next cycle out_valid=1, out_extop=000, out_illegal=0, out_pc=0x80000000.
- Back-to-back push of lui 0x123450b7, sw 0x00112023, beq 0x00208463, jal 0x008000ef, with out_ready=0 -> in_ready drops after 2 pushes, count=2. Head holds lui/001 stable. Raising out_ready drains 001, 010, then remaining entries in order: 011, 100.
- count=1 with simultaneous push and pop for 10 cycles -> count stays 1, in_ready stays 1, outputs follow input order with 1-cycle latency, no entries lost.
- Push opcode 0x0000007F -> extop=111, illegal=1. Push add 0x002081b3 -> extop=111, illegal=0. Push 0x0000006B -> extop=101.
- count=2 and in_valid=1, assert flush for 1 cycle -> next cycle out_valid=0, in_ready=1, the same-cycle input is dropped, and the next pushed instruction appears as head.
- rst_n pulsed low asynchronously mid-cycle with count=2 -> out_valid and in_ready go 0 immediately without a clock edge. With PERF_EN, perf_issue and perf_stall read 0.
